// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction-fetch stage
package if_pkg;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DROP
    } fetch_state_t;

    localparam logic [31:0] RESET_PC = 32'd0;
    localparam logic [31:0] PC_STEP  = 32'd4;
    localparam logic [31:0] NOP      = 32'd0;

endpackage

// File: rtl/if_pc_reg.sv
// rtl/if_pc_reg.sv - program counter with sync reset, branch load and step increment
module if_pc_reg #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(if_pkg::RESET_PC),
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(if_pkg::PC_STEP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    // Load wins over increment so a redirect never advances past its target.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_addr;
        end else if (inc) begin
            pc <= pc + PC_STEP;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - fetch stage: PC, imem req/ack handshake, freeze and redirect
module if_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(if_pkg::RESET_PC),
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(if_pkg::PC_STEP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] pc_out,
    output logic              if_valid
);

    import if_pkg::*;

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] branch_tgt;
    logic [DATA_W-1:0] buffer;
    logic              deliver_mem;
    logic              deliver_buf;

    assign branch_tgt  = branch_addr & ~ADDR_W'(3);
    assign deliver_mem = !rst && (state == FETCH) && imem_ack && !freeze && !branch_taken;
    assign deliver_buf = !rst && (state == HOLD) && !freeze && !branch_taken;

    if_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (branch_taken),
        .load_addr (branch_tgt),
        .inc       (if_valid),
        .pc        (pc)
    );

    // A redirect during DROP only retargets pc; the stale request must still drain.
    assign imem_req    = !rst && (state != HOLD);
    assign imem_addr   = rst ? '0 : ((state == DROP) ? req_addr : pc);
    assign if_valid    = deliver_mem || deliver_buf;
    assign instruction = deliver_mem ? imem_rdata : (deliver_buf ? buffer : DATA_W'(NOP));
    assign pc_out      = if_valid ? pc + PC_STEP : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            req_addr <= '0;
            buffer   <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (branch_taken) begin
                        if (!imem_ack) begin
                            req_addr <= pc;
                            state    <= DROP;
                        end
                    end else if (imem_ack && freeze) begin
                        buffer <= imem_rdata;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (branch_taken || !freeze) begin
                        buffer <= '0;
                        state  <= FETCH;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        if_valid;

    int tests = 0;
    int fails = 0;

    if_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .pc_out       (pc_out),
        .if_valid     (if_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        freeze = 0; branch_taken = 0; branch_addr = 0; imem_ack = 0; imem_rdata = 0;
    endtask

    task automatic do_reset();
        rst = 1; quiet();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; quiet();
        tick();
        #1;
        tests++;
        if ({imem_req, imem_addr, if_valid, instruction, pc_out} !== 98'd0) begin
            fails++;
            $display("FAIL reset_outputs: req=%0d addr=%h valid=%0d ins=%h pc_out=%h, want all 0",
                     imem_req, imem_addr, if_valid, instruction, pc_out);
        end
        tick();
        rst = 0;
        #1;
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0 || if_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_after: req=%0d addr=%h valid=%0d, want req=1 addr=0 valid=0",
                     imem_req, imem_addr, if_valid);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] w;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            w = $urandom; imem_ack = 1; imem_rdata = w;
            #1;
            tests++;
            if (imem_addr !== 32'(4 * i) || if_valid !== 1'b1 || pc_out !== 32'(4 * i + 4) || instruction !== w) begin
                fails++;
                $display("FAIL zero_wait[%0d]: addr=%h valid=%0d pc_out=%h ins=%h, want addr=%h valid=1 pc_out=%h ins=%h",
                         i, imem_addr, if_valid, pc_out, instruction, 4 * i, 4 * i + 4, w);
            end
            tick();
        end
        quiet();
    endtask

    task automatic test_slow_ack();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            imem_ack = (c == 2); imem_rdata = 32'h1234_5678;
            #1;
            tests++;
            if (imem_req !== 1'b1 || imem_addr !== 32'd0 || if_valid !== (c == 2) ||
                instruction !== ((c == 2) ? 32'h1234_5678 : 32'd0)) begin
                fails++;
                $display("FAIL slow_ack[%0d]: req=%0d addr=%h valid=%0d ins=%h", c, imem_req, imem_addr, if_valid, instruction);
            end
            tick();
        end
        quiet();
    endtask

    task automatic test_freeze_hold();
        do_reset();
        imem_ack = 1; imem_rdata = 32'h00A0_0093; freeze = 1;
        #1;
        tests++;
        if (if_valid !== 1'b0 || instruction !== 32'd0) begin
            fails++;
            $display("FAIL freeze_ack: valid=%0d ins=%h, want 0 0", if_valid, instruction);
        end
        tick();
        imem_ack = 0; imem_rdata = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests++;
            if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
                fails++;
                $display("FAIL freeze_hold[%0d]: req=%0d valid=%0d, want 0 0", c, imem_req, if_valid);
            end
            tick();
        end
        freeze = 0;
        #1;
        tests++;
        if (if_valid !== 1'b1 || instruction !== 32'h00A0_0093 || pc_out !== 32'd4) begin
            fails++;
            $display("FAIL freeze_release: valid=%0d ins=%h pc_out=%h, want 1 00a00093 4", if_valid, instruction, pc_out);
        end
        tick();
        #1;
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd4 || if_valid !== 1'b0) begin
            fails++;
            $display("FAIL freeze_next: req=%0d addr=%h valid=%0d, want 1 4 0", imem_req, imem_addr, if_valid);
        end
    endtask

    task automatic test_branch_wait();
        do_reset();
        imem_ack = 1;
        tick(); tick();
        imem_ack = 0; branch_taken = 1; branch_addr = 32'h40;
        #1;
        tests++;
        if (imem_addr !== 32'd8 || if_valid !== 1'b0) begin
            fails++;
            $display("FAIL branch_cycle: addr=%h valid=%0d, want 8 0", imem_addr, if_valid);
        end
        tick();
        branch_taken = 0;
        #1;
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd8) begin
            fails++;
            $display("FAIL branch_stale: req=%0d addr=%h, want 1 8", imem_req, imem_addr);
        end
        tick();
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        tests++;
        if (imem_addr !== 32'd8 || if_valid !== 1'b0 || instruction !== 32'd0) begin
            fails++;
            $display("FAIL branch_drop: addr=%h valid=%0d ins=%h, want 8 0 0", imem_addr, if_valid, instruction);
        end
        tick();
        quiet();
        #1;
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            fails++;
            $display("FAIL branch_target: req=%0d addr=%h, want 1 40", imem_req, imem_addr);
        end
    endtask

    task automatic test_hold_branch();
        do_reset();
        imem_ack = 1; imem_rdata = 32'h1111_2222; freeze = 1;
        tick();
        imem_ack = 0; branch_taken = 1; branch_addr = 32'h80;
        #1;
        tests++;
        if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
            fails++;
            $display("FAIL hold_branch: valid=%0d req=%0d, want 0 0", if_valid, imem_req);
        end
        tick();
        quiet();
        #1;
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h80 || if_valid !== 1'b0) begin
            fails++;
            $display("FAIL hold_branch_next: req=%0d addr=%h valid=%0d, want 1 80 0", imem_req, imem_addr, if_valid);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        imem_ack = 1;
        for (int i = 0; i < 4; i++) tick();
        imem_ack = 0;
        tick();
        rst = 1;
        #1;
        tests++;
        if ({imem_req, imem_addr, if_valid, instruction, pc_out} !== 98'd0) begin
            fails++;
            $display("FAIL mid_rst_cycle: req=%0d addr=%h valid=%0d, want all 0", imem_req, imem_addr, if_valid);
        end
        tick();
        rst = 0;
        #1;
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0 || if_valid !== 1'b0 || pc_out !== 32'd0) begin
            fails++;
            $display("FAIL mid_rst_after: req=%0d addr=%h valid=%0d pc_out=%h, want 1 0 0 0",
                     imem_req, imem_addr, if_valid, pc_out);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        branch_taken = 1; branch_addr = 32'hFFFF_FFFF; imem_ack = 1;
        tick();
        branch_taken = 0; imem_rdata = 32'hCAFE_0001;
        #1;
        tests++;
        if (imem_addr !== 32'hFFFF_FFFC || if_valid !== 1'b1 || pc_out !== 32'd0) begin
            fails++;
            $display("FAIL wrap: addr=%h valid=%0d pc_out=%h, want fffffffc 1 0", imem_addr, if_valid, pc_out);
        end
        tick();
        imem_ack = 0;
        #1;
        tests++;
        if (imem_addr !== 32'd0) begin
            fails++;
            $display("FAIL wrap_next: addr=%h, want 0", imem_addr);
        end
    endtask

    // Reference: pc advances per delivered word; a parked word or an outstanding
    // abandoned request each block new requests until resolved.
    task automatic test_random();
        logic [31:0] mpc, tgt, e_addr, e_ins, e_pc;
        logic        e_req, e_valid;
        logic [31:0] held_q[$];
        logic [31:0] stale_q[$];
        int          bad = 0;
        do_reset();
        mpc = 0;
        for (int n = 0; n < 4000; n++) begin
            rst          = ($urandom_range(0, 199) == 0);
            freeze       = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            branch_addr  = $urandom;
            imem_rdata   = $urandom;
            e_req        = !rst && (held_q.size() == 0);
            imem_ack     = e_req && ($urandom_range(0, 2) == 0);
            e_addr       = rst ? 32'd0 : ((stale_q.size() != 0) ? stale_q[0] : mpc);
            e_valid = 0; e_ins = 0; e_pc = 0;
            tgt = {branch_addr[31:2], 2'b00};
            if (rst) begin
                mpc = 0; held_q.delete(); stale_q.delete();
            end else if (held_q.size() != 0) begin
                if (branch_taken) begin
                    held_q.delete(); mpc = tgt;
                end else if (!freeze) begin
                    e_valid = 1; e_ins = held_q.pop_front(); e_pc = mpc + 4; mpc = mpc + 4;
                end
            end else if (stale_q.size() != 0) begin
                if (imem_ack) void'(stale_q.pop_front());
                if (branch_taken) mpc = tgt;
            end else if (branch_taken) begin
                if (!imem_ack) stale_q.push_back(mpc);
                mpc = tgt;
            end else if (imem_ack && freeze) begin
                held_q.push_back(imem_rdata);
            end else if (imem_ack) begin
                e_valid = 1; e_ins = imem_rdata; e_pc = mpc + 4; mpc = mpc + 4;
            end
            #1;
            tests++;
            if (imem_req !== e_req || (e_req && imem_addr !== e_addr) || if_valid !== e_valid ||
                instruction !== e_ins || pc_out !== e_pc) begin
                fails++;
                if (bad++ < 10)
                    $display("FAIL random[%0d]: req=%0d addr=%h valid=%0d ins=%h pc_out=%h, want %0d %h %0d %h %h",
                             n, imem_req, imem_addr, if_valid, instruction, pc_out, e_req, e_addr, e_valid, e_ins, e_pc);
            end
            tick();
        end
        rst = 0; quiet();
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_slow_ack();
        test_freeze_hold();
        test_branch_wait();
        test_hold_branch();
        test_reset_mid_wait();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
